seven_seg_scanner: RTL and testbench
====================================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, SHALL set the CLK cycles each digit slot is held (legal >= 4).
REQ-002 Parameter GUARD, default 2, SHALL set the CLK cycles at the start of each slot during which all digits are off (legal 0..REFRESH_DIV-2).
REQ-003 Parameter SEG_ACT_LOW, default 1, SHALL select the segment drive polarity (1 = active-low).
REQ-004 Parameter DIG_ACT_LOW, default 1, SHALL select the digit-enable drive polarity (1 = active-low).
REQ-005 CLK  input  1  SHALL be the single clock; all state is on its rising edge.
REQ-006 RST_N  input  1  SHALL be the reset: asynchronous and active-low.
REQ-007 IN1..IN6  input  5 each  SHALL be the display codes; INk drives digit slot k-1.
REQ-008 UPDATE  input  1  SHALL be the load strobe; it is sampled every cycle.
REQ-009 BLANK  input  1  SHALL force all digits off while high.
REQ-010 SEG  output  7  SHALL be the segment drive in bit order {g,f,e,d,c,b,a}.
REQ-011 DIGIT  output  6  SHALL be the one-hot digit enables; bit k corresponds to slot k.
REQ-012 FRAME_DONE  output  1  SHALL pulse for one cycle when slot 5 ends.

Function
REQ-013 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap; the slot index SHALL advance 0->1->...->5->0 on each wrap.
REQ-014 The code decode SHALL be as follows (logical active-high gfedcba):
- 0..F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71
- 10000 = blank 00; 10001 = dash 40
- 10100 A = 77; 10110 J = 1E; 10111 U = 3E; 11000 M = 37; 11001 P = 73; 11010 S = 6D; 11011 V = 1C; 11101 E = 79
- All other codes = blank
REQ-015 SEG and DIGIT SHALL be registered and SHALL reflect the current slot index and prescaler one cycle later.
REQ-016 DIGIT SHALL be all-off while prescaler < GUARD, while BLANK = 1, or while the slot's code decodes to blank; otherwise exactly the current slot bit SHALL be on.
REQ-017 While its digit is off, SEG SHALL be held at the inactive level.
REQ-018 Polarity inversion SHALL be applied only at the output registers.
REQ-019 When UPDATE = 1, IN1..IN6 SHALL be captured into a pending bank and a pending flag SHALL be set; a later UPDATE SHALL overwrite the pending bank.
REQ-020 On the edge where slot 5 wraps to slot 0, if the pending flag is set, the pending bank SHALL be copied to the active bank and the flag cleared, so no frame shows mixed old and new codes.
REQ-021 If UPDATE coincides with the 5->0 wrap edge, the inputs at that edge SHALL load directly into the active bank and the flag SHALL end cleared.
REQ-022 FRAME_DONE SHALL be asserted, registered, in the cycle after the 5->0 wrap edge.
REQ-023 BLANK SHALL NOT stop the prescaler, the slot index, or the bank transfer.

Reset
REQ-024 While RST_N = 0, the block SHALL hold: prescaler 0, slot 0, active and pending banks all 10000, pending flag 0, SEG and DIGIT at their inactive levels, FRAME_DONE 0.
REQ-025 Reset assertion mid-slot or mid-update SHALL discard any pending update; after release, scanning SHALL restart at slot 0 with the guard interval.

Structure
REQ-026 Package seg7_pkg SHALL hold:
- code constants CODE_BLANK = 5'h10, CODE_DASH = 5'h11, and the letter codes
- the 7-bit segment pattern constants
REQ-027 A combinational sub-module seg7_decode (5-bit code in, logical 7-bit pattern out) SHALL implement REQ-014 and SHALL be instantiated once on the muxed active code.

Verification (REFRESH_DIV = 4, GUARD = 1, both polarities active-low)
REQ-028 Release reset with no UPDATE -> DIGIT = 3F and SEG = 7F for all cycles; FRAME_DONE pulses every 24 cycles.
REQ-029 UPDATE one cycle with IN1..IN6 = 0,1,2,3,10001,10000 -> from the next frame, slots 0..3 show SEG = 40,79,24,30 and slot 4 shows 3F; slot 5 keeps DIGIT = 3F; each lit slot is off for its first cycle.
REQ-030 Pulse UPDATE with 8s during slot 2, then with 9s during slot 4 -> the current frame remains unchanged; the next frame shows only 9s (SEG = 10).
REQ-031 UPDATE with IN2..IN5 = 11010,10100,11011,11101 on the exact 5->0 wrap edge -> that same frame shows S,A,V,E (SEG = 12,08,63,06) in slots 1..4.
REQ-032 BLANK high for 30 cycles -> DIGIT = 3F throughout, and FRAME_DONE timing is unchanged.
REQ-033 Drive RST_N low during slot 3 with an update pending -> outputs go inactive immediately; after release, all slots are blank and scanning starts at slot 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the six-digit seven-segment scanner:
//   - 5-bit display code constants (blank, dash, letters)
//   - logical (active-high, {g,f,e,d,c,b,a}) segment patterns
//   - slot index enumeration and a slot-to-one-hot helper
package seg7_pkg;

   // Display codes beyond the 0..F hex range
   localparam logic [4:0] CODE_BLANK = 5'h10;
   localparam logic [4:0] CODE_DASH  = 5'h11;
   localparam logic [4:0] CODE_A     = 5'h14;
   localparam logic [4:0] CODE_J     = 5'h16;
   localparam logic [4:0] CODE_U     = 5'h17;
   localparam logic [4:0] CODE_M     = 5'h18;
   localparam logic [4:0] CODE_P     = 5'h19;
   localparam logic [4:0] CODE_S     = 5'h1A;
   localparam logic [4:0] CODE_V     = 5'h1B;
   localparam logic [4:0] CODE_E     = 5'h1D;

   // Logical segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] PAT_HEX_0 = 7'h3F;
   localparam logic [6:0] PAT_HEX_1 = 7'h06;
   localparam logic [6:0] PAT_HEX_2 = 7'h5B;
   localparam logic [6:0] PAT_HEX_3 = 7'h4F;
   localparam logic [6:0] PAT_HEX_4 = 7'h66;
   localparam logic [6:0] PAT_HEX_5 = 7'h6D;
   localparam logic [6:0] PAT_HEX_6 = 7'h7D;
   localparam logic [6:0] PAT_HEX_7 = 7'h07;
   localparam logic [6:0] PAT_HEX_8 = 7'h7F;
   localparam logic [6:0] PAT_HEX_9 = 7'h6F;
   localparam logic [6:0] PAT_HEX_A = 7'h77;
   localparam logic [6:0] PAT_HEX_B = 7'h7C;
   localparam logic [6:0] PAT_HEX_C = 7'h39;
   localparam logic [6:0] PAT_HEX_D = 7'h5E;
   localparam logic [6:0] PAT_HEX_E = 7'h79;
   localparam logic [6:0] PAT_HEX_F = 7'h71;
   localparam logic [6:0] PAT_BLANK = 7'h00;
   localparam logic [6:0] PAT_DASH  = 7'h40;
   localparam logic [6:0] PAT_LTR_A = 7'h77;
   localparam logic [6:0] PAT_LTR_J = 7'h1E;
   localparam logic [6:0] PAT_LTR_U = 7'h3E;
   localparam logic [6:0] PAT_LTR_M = 7'h37;
   localparam logic [6:0] PAT_LTR_P = 7'h73;
   localparam logic [6:0] PAT_LTR_S = 7'h6D;
   localparam logic [6:0] PAT_LTR_V = 7'h1C;
   localparam logic [6:0] PAT_LTR_E = 7'h79;

   // Digit slot index; slot k is driven by input IN(k+1)
   typedef enum logic [2:0] {
      SLOT0 = 3'd0,
      SLOT1 = 3'd1,
      SLOT2 = 3'd2,
      SLOT3 = 3'd3,
      SLOT4 = 3'd4,
      SLOT5 = 3'd5
   } slot_e;

   // One-hot digit enable (logical, active-high) for a slot
   function automatic logic [5:0] slot_onehot(input slot_e slot);
      logic [5:0] oh;
      case (slot)
         SLOT0:   oh = 6'b000001;
         SLOT1:   oh = 6'b000010;
         SLOT2:   oh = 6'b000100;
         SLOT3:   oh = 6'b001000;
         SLOT4:   oh = 6'b010000;
         SLOT5:   oh = 6'b100000;
         default: oh = 6'b000000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
// Combinational display-code decoder.
// Ports:
//   code    in  5  display code (0..F hex, blank, dash, letters)
//   pattern out 7  logical active-high segments {g,f,e,d,c,b,a};
//                  unknown codes decode to blank
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [4:0] code,
   output logic [6:0] pattern
);

   // Code-to-pattern lookup
   always_comb begin
      pattern = PAT_BLANK;
      case (code)
         5'h00:      pattern = PAT_HEX_0;
         5'h01:      pattern = PAT_HEX_1;
         5'h02:      pattern = PAT_HEX_2;
         5'h03:      pattern = PAT_HEX_3;
         5'h04:      pattern = PAT_HEX_4;
         5'h05:      pattern = PAT_HEX_5;
         5'h06:      pattern = PAT_HEX_6;
         5'h07:      pattern = PAT_HEX_7;
         5'h08:      pattern = PAT_HEX_8;
         5'h09:      pattern = PAT_HEX_9;
         5'h0A:      pattern = PAT_HEX_A;
         5'h0B:      pattern = PAT_HEX_B;
         5'h0C:      pattern = PAT_HEX_C;
         5'h0D:      pattern = PAT_HEX_D;
         5'h0E:      pattern = PAT_HEX_E;
         5'h0F:      pattern = PAT_HEX_F;
         CODE_BLANK: pattern = PAT_BLANK;
         CODE_DASH:  pattern = PAT_DASH;
         CODE_A:     pattern = PAT_LTR_A;
         CODE_J:     pattern = PAT_LTR_J;
         CODE_U:     pattern = PAT_LTR_U;
         CODE_M:     pattern = PAT_LTR_M;
         CODE_P:     pattern = PAT_LTR_P;
         CODE_S:     pattern = PAT_LTR_S;
         CODE_V:     pattern = PAT_LTR_V;
         CODE_E:     pattern = PAT_LTR_E;
         default:    pattern = PAT_BLANK;
      endcase
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
// Time-multiplexed driver for a six-digit seven-segment display.
// Each slot is held REFRESH_DIV cycles; the first GUARD cycles of a slot
// keep all digits dark to avoid ghosting. New codes are staged in a
// pending bank and only copied to the active bank at the frame boundary,
// so a frame never mixes old and new codes.
// Ports:
//   CLK        in  1  clock, rising edge
//   RST_N      in  1  asynchronous active-low reset
//   IN1..IN6   in  5  display codes, INk drives slot k-1
//   UPDATE     in  1  load strobe for IN1..IN6
//   BLANK      in  1  force all digits off
//   SEG        out 7  registered segment drive {g,f,e,d,c,b,a}
//   DIGIT      out 6  registered one-hot digit enables, bit k = slot k
//   FRAME_DONE out 1  one-cycle pulse after slot 5 ends
module seven_seg_scanner
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD       = 2,
   parameter int SEG_ACT_LOW = 1,
   parameter int DIG_ACT_LOW = 1
)(
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [4:0] IN1,
   input  logic [4:0] IN2,
   input  logic [4:0] IN3,
   input  logic [4:0] IN4,
   input  logic [4:0] IN5,
   input  logic [4:0] IN6,
   input  logic       UPDATE,
   input  logic       BLANK,
   output logic [6:0] SEG,
   output logic [5:0] DIGIT,
   output logic       FRAME_DONE
);

   localparam int            PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   // Inactive levels double as XOR masks for polarity inversion
   localparam logic [6:0]    SEG_OFF    = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [5:0]    DIG_OFF    = (DIG_ACT_LOW != 0) ? 6'h3F : 6'h00;

   logic [PW-1:0]   presc_r;
   slot_e           slot_r;
   slot_e           slot_nxt_s;
   logic            presc_wrap_s;
   logic            frame_end_s;
   logic [5:0][4:0] in_bank_s;
   logic [5:0][4:0] pend_r;
   logic [5:0][4:0] act_r;
   logic            pend_flag_r;
   logic [4:0]      act_code_s;
   logic [6:0]      pattern_s;
   logic            guard_ok_s;
   logic            lit_s;
   logic [6:0]      seg_log_s;
   logic [5:0]      dig_log_s;

   assign in_bank_s    = {IN6, IN5, IN4, IN3, IN2, IN1};
   assign presc_wrap_s = (presc_r == PRESC_LAST);
   assign frame_end_s  = presc_wrap_s && (slot_r == SLOT5);

   // With no guard the comparison would be trivially true, so elide it
   generate
      if (GUARD == 0) begin : g_no_guard
         assign guard_ok_s = 1'b1;
      end else begin : g_guard
         assign guard_ok_s = (presc_r >= PW'(GUARD));
      end
   endgenerate

   // Prescaler: counts cycles within the current slot
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         presc_r <= '0;
      end else if (presc_wrap_s) begin
         presc_r <= '0;
      end else begin
         presc_r <= presc_r + PW'(1);
      end
   end

   // Slot index state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         slot_r <= SLOT0;
      end else begin
         slot_r <= slot_nxt_s;
      end
   end

   // Slot index next state: advance on each prescaler wrap
   always_comb begin
      slot_nxt_s = slot_r;
      if (presc_wrap_s) begin
         case (slot_r)
            SLOT0:   slot_nxt_s = SLOT1;
            SLOT1:   slot_nxt_s = SLOT2;
            SLOT2:   slot_nxt_s = SLOT3;
            SLOT3:   slot_nxt_s = SLOT4;
            SLOT4:   slot_nxt_s = SLOT5;
            SLOT5:   slot_nxt_s = SLOT0;
            default: slot_nxt_s = SLOT0;
         endcase
      end else begin
         slot_nxt_s = slot_r;
      end
   end

   // Pending/active code banks; an UPDATE on the frame edge bypasses pending
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pend_r      <= {6{CODE_BLANK}};
         act_r       <= {6{CODE_BLANK}};
         pend_flag_r <= 1'b0;
      end else if (frame_end_s) begin
         if (UPDATE) begin
            act_r <= in_bank_s;
         end else if (pend_flag_r) begin
            act_r <= pend_r;
         end else begin
            act_r <= act_r;
         end
         pend_flag_r <= 1'b0;
      end else if (UPDATE) begin
         pend_r      <= in_bank_s;
         pend_flag_r <= 1'b1;
      end else begin
         pend_flag_r <= pend_flag_r;
      end
   end

   // Select the active code for the slot being displayed
   always_comb begin
      act_code_s = CODE_BLANK;
      case (slot_r)
         SLOT0:   act_code_s = act_r[0];
         SLOT1:   act_code_s = act_r[1];
         SLOT2:   act_code_s = act_r[2];
         SLOT3:   act_code_s = act_r[3];
         SLOT4:   act_code_s = act_r[4];
         SLOT5:   act_code_s = act_r[5];
         default: act_code_s = CODE_BLANK;
      endcase
   end

   seg7_decode u_decode (
      .code    (act_code_s),
      .pattern (pattern_s)
   );

   // Logical (active-high) drive; segments go dark whenever the digit is off
   always_comb begin
      seg_log_s = PAT_BLANK;
      dig_log_s = 6'b000000;
      lit_s     = guard_ok_s && !BLANK && (pattern_s != PAT_BLANK);
      if (lit_s) begin
         seg_log_s = pattern_s;
         dig_log_s = slot_onehot(slot_r);
      end else begin
         seg_log_s = PAT_BLANK;
         dig_log_s = 6'b000000;
      end
   end

   // Output registers; polarity is applied only here
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         SEG        <= SEG_OFF;
         DIGIT      <= DIG_OFF;
         FRAME_DONE <= 1'b0;
      end else begin
         SEG        <= seg_log_s ^ SEG_OFF;
         DIGIT      <= dig_log_s ^ DIG_OFF;
         FRAME_DONE <= frame_end_s;
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner
// Directed self-checking bench for seven_seg_scanner with REFRESH_DIV = 4,
// GUARD = 1 and active-low segment and digit drive. A frame is 24 cycles;
// frames are checked cycle by cycle against hand-derived patterns.
module tb_seven_seg_scanner;

   logic       clk;
   logic       rst_n;
   logic [4:0] in1, in2, in3, in4, in5, in6;
   logic       update;
   logic       blank;
   logic [6:0] seg;
   logic [5:0] digit;
   logic       frame_done;

   int checks = 0;
   int errors = 0;

   // Expected active-low frames (index = slot)
   localparam logic [5:0][6:0] SEG_DARK = {6{7'h7F}};
   localparam logic [5:0][6:0] SEG_029  = {7'h7F, 7'h3F, 7'h30, 7'h24, 7'h79, 7'h40};
   localparam logic [5:0][6:0] SEG_NINE = {6{7'h10}};
   localparam logic [5:0][6:0] SEG_SAVE = {7'h7F, 7'h06, 7'h63, 7'h08, 7'h12, 7'h7F};
   // Code banks (index 0 = IN1)
   localparam logic [5:0][4:0] C_029    = {5'h10, 5'h11, 5'h03, 5'h02, 5'h01, 5'h00};
   localparam logic [5:0][4:0] C_EIGHT  = {6{5'h08}};
   localparam logic [5:0][4:0] C_NINE   = {6{5'h09}};
   localparam logic [5:0][4:0] C_SAVE   = {5'h10, 5'h1D, 5'h1B, 5'h14, 5'h1A, 5'h10};

   seven_seg_scanner #(
      .REFRESH_DIV (4),
      .GUARD       (1),
      .SEG_ACT_LOW (1),
      .DIG_ACT_LOW (1)
   ) dut (
      .CLK        (clk),
      .RST_N      (rst_n),
      .IN1        (in1),
      .IN2        (in2),
      .IN3        (in3),
      .IN4        (in4),
      .IN5        (in5),
      .IN6        (in6),
      .UPDATE     (update),
      .BLANK      (blank),
      .SEG        (seg),
      .DIGIT      (digit),
      .FRAME_DONE (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_codes(input logic [5:0][4:0] c);
      in1 = c[0]; in2 = c[1]; in3 = c[2]; in4 = c[3]; in5 = c[4]; in6 = c[5];
   endtask

   // Run one frame starting in the cycle FRAME_DONE is high; optional
   // UPDATE pulses are driven at cycle indices ua/ub (-1 = none).
   task automatic run_frame(input string name, input logic [5:0][6:0] eseg,
                            input logic [5:0] elit,
                            input int ua, input logic [5:0][4:0] ca,
                            input int ub, input logic [5:0][4:0] cb);
      int s, p;
      logic [5:0] oh;
      logic lit;
      for (int j = 0; j < 24; j++) begin
         if (j == ua) begin
            update = 1'b1;
            drive_codes(ca);
         end else if (j == ub) begin
            update = 1'b1;
            drive_codes(cb);
         end else begin
            update = 1'b0;
         end
         tick();
         update = 1'b0;
         s   = j / 4;
         p   = j % 4;
         oh  = 6'b000001 << s;
         lit = (p >= 1) && elit[s];
         chk($sformatf("%s digit c%0d", name, j + 1), {26'd0, digit}, {26'd0, lit ? ~oh : 6'h3F});
         chk($sformatf("%s seg c%0d", name, j + 1), {25'd0, seg}, {25'd0, lit ? eseg[s] : 7'h7F});
         chk($sformatf("%s frame_done c%0d", name, j + 1), {31'd0, frame_done}, {31'd0, (j == 23)});
      end
   endtask

   // Reset, check inactive outputs, release, then expect a dark first frame
   // whose FRAME_DONE lands exactly 24 edges after release.
   task automatic do_reset(input string name);
      rst_n = 1'b0;
      #1;
      chk({name, " rst seg"}, {25'd0, seg}, 32'h7F);
      chk({name, " rst digit"}, {26'd0, digit}, 32'h3F);
      chk({name, " rst frame_done"}, {31'd0, frame_done}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         tick();
         chk($sformatf("%s first digit c%0d", name, k), {26'd0, digit}, 32'h3F);
         chk($sformatf("%s first seg c%0d", name, k), {25'd0, seg}, 32'h7F);
         chk($sformatf("%s first frame_done c%0d", name, k), {31'd0, frame_done}, {31'd0, (k == 24)});
      end
   endtask

   task automatic wait_frame(input string name);
      logic found;
      found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
         tick();
         found = frame_done;
      end
      chk({name, " frame_done timeout"}, {31'd0, found}, 32'd1);
   endtask

   initial begin
      rst_n  = 1'b0;
      update = 1'b0;
      blank  = 1'b0;
      drive_codes({6{5'h00}});
      #12;

      // Reset state, dark scanning and 24-cycle frame period
      do_reset("init");
      run_frame("idle", SEG_DARK, 6'b000000, -1, C_029, -1, C_029);

      // Staged update: current frame stays dark, next frame shows codes
      run_frame("stage", SEG_DARK, 6'b000000, 0, C_029, -1, C_029);
      run_frame("show029", SEG_029, 6'b011111, -1, C_029, -1, C_029);

      // Two updates mid-frame: frame unchanged, only the later one lands
      run_frame("overwrite", SEG_029, 6'b011111, 9, C_EIGHT, 17, C_NINE);
      // Update on the exact wrap edge goes straight into the next frame
      run_frame("nines", SEG_NINE, 6'b111111, 23, C_SAVE, -1, C_SAVE);
      run_frame("save", SEG_SAVE, 6'b011110, -1, C_SAVE, -1, C_SAVE);

      // BLANK for 30 cycles: dark, frame timing and bank transfer continue
      blank = 1'b1;
      run_frame("blank", SEG_DARK, 6'b000000, 5, C_029, -1, C_029);
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("blank tail digit c%0d", k), {26'd0, digit}, 32'h3F);
         chk($sformatf("blank tail frame_done c%0d", k), {31'd0, frame_done}, 32'd0);
      end
      blank = 1'b0;
      wait_frame("blank end");
      run_frame("after blank", SEG_029, 6'b011111, -1, C_029, -1, C_029);

      // Reset in slot 3 with an update pending
      update = 1'b1;
      drive_codes(C_EIGHT);
      tick();
      update = 1'b0;
      repeat (13) tick();
      chk("pre-reset digit", {26'd0, digit}, 32'h37);
      chk("pre-reset seg", {25'd0, seg}, 32'h30);
      do_reset("midslot");
      run_frame("discarded", SEG_DARK, 6'b000000, -1, C_029, -1, C_029);
      run_frame("reload", SEG_DARK, 6'b000000, 0, C_029, -1, C_029);
      run_frame("reload show", SEG_029, 6'b011111, -1, C_029, -1, C_029);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
